// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: widths, field positions, opcodes, states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 29;
    localparam int OP_W    = 5;
    localparam int FIELD_W = 8;

    // Most-significant bit of each instruction field
    localparam int OP_MSB   = 28;
    localparam int DEST_MSB = 23;
    localparam int SRC1_MSB = 15;
    localparam int SRC2_MSB = 7;

    localparam logic [OP_W-1:0] OP_NOP    = 5'h00;
    localparam logic [OP_W-1:0] OP_ALU_LO = 5'h01;
    localparam logic [OP_W-1:0] OP_ALU_HI = 5'h0F;
    localparam logic [OP_W-1:0] OP_JMP    = 5'h10;
    localparam logic [OP_W-1:0] OP_JZ     = 5'h11;
    localparam logic [OP_W-1:0] OP_HALT   = 5'h1F;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    // Decoded view of one instruction word
    typedef struct packed {
        logic [OP_W-1:0]    opcode;
        logic [FIELD_W-1:0] dest;
        logic [FIELD_W-1:0] src1;
        logic [FIELD_W-1:0] src2;
    } instr_t;

endpackage

// File: rtl/seq_decode.sv
// Splits the latched instruction into fields and classifies the opcode.
// Latency: purely combinational.
// Backpressure: none.
module seq_decode
    import seq_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [OP_W-1:0]    opcode,
    output logic [FIELD_W-1:0] dest,
    output logic [FIELD_W-1:0] src1,
    output logic [FIELD_W-1:0] src2,
    output logic               is_alu,
    output logic               is_jmp,
    output logic               is_jz,
    output logic               is_halt,
    output logic               is_illegal
);

    assign opcode = ir[OP_MSB   -: OP_W];
    assign dest   = ir[DEST_MSB -: FIELD_W];
    assign src1   = ir[SRC1_MSB -: FIELD_W];
    assign src2   = ir[SRC2_MSB -: FIELD_W];

    // Opcode classification; anything not recognised is flagged illegal
    always_comb begin
        is_alu     = 1'b0;
        is_jmp     = 1'b0;
        is_jz      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP:  ;
            OP_JMP:  is_jmp  = 1'b1;
            OP_JZ:   is_jz   = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: begin
                if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) begin
                    is_alu = 1'b1;
                end else begin
                    is_illegal = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control with PC, IR and jump handling.
// Latency: NOP/JMP/JZ/illegal 2 cycles, ALU op 4 cycles minimum.
// Backpressure: in_alu_ready low holds EXECUTE; no other flow control.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               in_start,
    input  logic [INSTR_W-1:0] in_instruction,
    input  logic               in_alu_ready,
    input  logic               in_zero,
    output logic [ADDR_W-1:0]  out_add,
    output logic [OP_W-1:0]    out_opcode,
    output logic [FIELD_W-1:0] out_dest,
    output logic [FIELD_W-1:0] out_src1,
    output logic [FIELD_W-1:0] out_src2,
    output logic               out_alu_en,
    output logic               out_reg_we,
    output logic               out_halted,
    output logic               out_illegal,
    output logic [2:0]         out_state
);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [ADDR_W-1:0]   pc_inc;
    logic [INSTR_W-1:0]  ir_q;
    logic                ir_load;

    logic                dec_alu;
    logic                dec_jmp;
    logic                dec_jz;
    logic                dec_halt;
    logic                dec_illegal;

    // Fields come straight from IR, so they only move when IR is reloaded in FETCH
    seq_decode u_decode (
        .ir         (ir_q),
        .opcode     (out_opcode),
        .dest       (out_dest),
        .src1       (out_src1),
        .src2       (out_src2),
        .is_alu     (dec_alu),
        .is_jmp     (dec_jmp),
        .is_jz      (dec_jz),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    // Natural ADDR_W-bit add wraps the PC at the top of program memory
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign out_add   = pc_q;
    assign out_state = state_q;

    // State, PC and instruction registers; reset overrides any in-flight instruction
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ir_load) begin
                ir_q <= in_instruction;
            end
        end
    end

    // Next-state, next-PC and strobe decode
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_load     = 1'b0;
        out_alu_en  = 1'b0;
        out_reg_we  = 1'b0;
        out_halted  = 1'b0;
        out_illegal = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    state_d = ST_FETCH;
                    pc_d    = RESET_PC;
                end
            end
            ST_FETCH: begin
                ir_load = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                out_illegal = dec_illegal;
                if (dec_alu) begin
                    state_d = ST_EXECUTE;
                end else if (dec_jmp) begin
                    pc_d    = ADDR_W'(out_src2);
                    state_d = ST_FETCH;
                end else if (dec_jz) begin
                    pc_d    = in_zero ? ADDR_W'(out_src2) : pc_inc;
                    state_d = ST_FETCH;
                end else if (dec_halt) begin
                    state_d = ST_HALT;
                end else begin
                    // NOP and illegal opcodes both just step to the next word
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                out_alu_en = 1'b1;
                if (in_alu_ready) begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                out_reg_we = 1'b1;
                pc_d       = pc_inc;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                out_halted = 1'b1;
                if (in_start) begin
                    state_d = ST_FETCH;
                    pc_d    = RESET_PC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Multi-cycle control unit for the processor core. It drives the program-memory address (PC), latches the combinationally-read 29-bit instruction, and splits it into fields: opcode[28:24], dest[23:16], src1[15:8], src2/imm[7:0]. It sequences FETCH/DECODE/EXECUTE/WRITEBACK for the ALU and register file, and handles jumps, conditional jumps and halt.

Parameters:
ADDR_W, 8, PC / program-memory address width
INSTR_W, 29, instruction width
OP_W, 5, opcode field width
FIELD_W, 8, dest/src1/src2 field width
RESET_PC, 0, PC value after reset and on restart

Ports:
in_clk  input  1  clock, all state updates on rising edge
in_rst  input  1  synchronous, active-high reset
in_start  input  1  leave IDLE/HALT and begin fetching at RESET_PC
in_instruction  input  INSTR_W  instruction read from program memory at out_add (same-cycle, combinational)
in_alu_ready  input  1  ALU result valid; ends EXECUTE
in_zero  input  1  zero flag from datapath, sampled in DECODE
out_add  output  ADDR_W  program-memory address (PC)
out_opcode  output  OP_W  latched opcode
out_dest  output  FIELD_W  latched destination register
out_src1  output  FIELD_W  latched source 1
out_src2  output  FIELD_W  latched source 2 / immediate
out_alu_en  output  1  high throughout EXECUTE
out_reg_we  output  1  one-cycle register-file write strobe
out_halted  output  1  high in HALT
out_illegal  output  1  one-cycle pulse on an undefined opcode
out_state  output  3  current state, for debug

Behaviour:
- Clock and reset: single clock in_clk. in_rst is synchronous and active-high, sampled at the rising edge, and overrides everything including a mid-instruction state.
- Reset values: state=IDLE, PC=RESET_PC, IR=0, all field outputs 0, out_alu_en=0, out_reg_we=0, out_halted=0, out_illegal=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
- IDLE: wait for in_start=1, then go to FETCH with PC=RESET_PC.
- FETCH: out_add=PC. IR <= in_instruction at the edge. Next state is DECODE.
- DECODE: fields are driven from IR; decode acts on the opcode:
  - 5'h00 NOP: PC<=PC+1, go to FETCH.
  - 5'h01–5'h0F ALU op: go to EXECUTE.
  - 5'h10 JMP: PC<=imm[7:0], go to FETCH.
  - 5'h11 JZ: if in_zero then PC<=imm, else PC<=PC+1; go to FETCH.
  - 5'h1F HALT: PC unchanged, go to HALT.
  - Any other opcode: out_illegal pulses for 1 cycle, then it behaves as NOP.
- EXECUTE: out_alu_en=1. Stay in EXECUTE while in_alu_ready=0. in_alu_ready=1 in the first EXECUTE cycle gives a 1-cycle EXECUTE. Next state is WRITEBACK.
- WRITEBACK: out_reg_we=1 for exactly 1 cycle, PC<=PC+1, go to FETCH.
- Latency: ALU op takes a minimum of 4 cycles. NOP, JMP and JZ take 2 cycles.
- HALT: out_halted=1 and the field outputs hold. in_start=1 restarts at FETCH with PC=RESET_PC. in_start is ignored in all states other than IDLE and HALT.
- PC arithmetic: modulo 2^ADDR_W, so 255+1 wraps to 0.
- Field outputs are stable from DECODE through WRITEBACK and change only at FETCH.
- in_alu_ready outside EXECUTE is ignored.
- in_rst and in_start high in the same cycle: reset wins.

Decomposition:
- Shared package seq_pkg:
  - opcode constants OP_NOP, OP_ALU_LO/HI, OP_JMP, OP_JZ, OP_HALT
  - state encodings
  - field bit-position constants (OP_MSB=28, DEST_MSB=23, SRC1_MSB=15, SRC2_MSB=7)
  - widths
- One sub-module, seq_decode: combinational IR → {opcode, dest, src1, src2, is_alu, is_jmp, is_jz, is_halt, is_illegal}.
- The FSM and PC register stay in instruction_sequencer.

Test Plan:
1. Reset then in_start; memory[0]=0 → out_add 0→1 after 2 cycles; no out_reg_we; no out_illegal.
2. Memory[1]=29'b00001_00000010_00000000_00000001, in_alu_ready tied high → DECODE shows opcode=1, dest=2, src1=0, src2=1; out_alu_en for 1 cycle; out_reg_we for 1 cycle; out_add=2 four cycles after FETCH of address 1.
3. ALU op with in_alu_ready held low for 5 cycles → out_alu_en high for 6 cycles; single out_reg_we pulse; PC advances by exactly 1.
4. JMP imm=8'hFF, then NOP at 255 → PC=255, then wraps to 0. JZ imm=8'h10 with in_zero=1 → PC=0x10; with in_zero=0 → PC+1.
5. HALT at address 5 → out_halted=1, out_add stays 5 indefinitely; in_start → FETCH at 0, out_halted=0.
6. Opcode 5'h15 → single out_illegal pulse, PC+1. Assert in_rst during EXECUTE with in_alu_ready low → next cycle state=IDLE, out_add=0, all strobes 0.
